// File: rtl/div_pkg.sv
// Shared widths, state encoding and iteration constants for the div8by4_seq divider.
// DIV_RADIX4_EN selects two quotient bits per cycle instead of one.
package div_pkg;

   localparam int DIVIDEND_W = 8;
   localparam int DIVISOR_W  = 4;
   localparam int REM_W      = DIVISOR_W + 1;

`ifdef DIV_RADIX4_EN
   localparam int STEPS_PER_CYC = 2;
`else
   localparam int STEPS_PER_CYC = 1;
`endif

   localparam int ITERS = DIVIDEND_W / STEPS_PER_CYC;
   localparam int CNT_W = $clog2(ITERS);

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits, and report the resulting quotient bit.
module div_step
   import div_pkg::*;
(
   input  logic [REM_W-1:0]     rem_in,
   input  logic                 bit_in,
   input  logic [DIVISOR_W-1:0] B,
   output logic [REM_W-1:0]     rem_out,
   output logic                 q_bit
);

   logic [REM_W-1:0] shifted;

   assign shifted = {rem_in[REM_W-2:0], bit_in};

   // A set top bit on the incoming remainder means the shifted value overflowed
   // REM_W bits, so it certainly exceeds any 4-bit divisor.
   assign q_bit   = rem_in[REM_W-1] | (shifted >= {1'b0, B});
   assign rem_out = q_bit ? (shifted - {1'b0, B}) : shifted;

endmodule

// File: rtl/div8by4_seq.sv
// Sequential restoring divider, 8-bit dividend by 4-bit divisor, valid/ready on both sides.
// Define DIV_RADIX4_EN to retire two quotient bits per CALC cycle.
module div8by4_seq
   import div_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DIVIDEND_W-1:0] P,
   input  logic [DIVISOR_W-1:0]  B,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DIVIDEND_W-1:0] Q,
   output logic [DIVISOR_W-1:0]  R,
   output logic                  dz
);

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ITERS - 1);

   state_t                  state, state_next;
   logic [CNT_W-1:0]        cnt;
   logic [DIVIDEND_W-1:0]   dvd;
   logic [DIVISOR_W-1:0]    divisor;
   logic [REM_W-1:0]        rem;
   logic [REM_W-1:0]        rem_step;
   logic [DIVIDEND_W-1:0]   q_acc;
   logic [DIVIDEND_W-1:0]   q_acc_next;
   logic [STEPS_PER_CYC-1:0] q_bits;

`ifdef DIV_RADIX4_EN
   logic [REM_W-1:0] rem_mid;

   div_step u_step_hi (
      .rem_in  (rem),
      .bit_in  (dvd[DIVIDEND_W-1]),
      .B       (divisor),
      .rem_out (rem_mid),
      .q_bit   (q_bits[1])
   );

   div_step u_step_lo (
      .rem_in  (rem_mid),
      .bit_in  (dvd[DIVIDEND_W-2]),
      .B       (divisor),
      .rem_out (rem_step),
      .q_bit   (q_bits[0])
   );
`else
   div_step u_step (
      .rem_in  (rem),
      .bit_in  (dvd[DIVIDEND_W-1]),
      .B       (divisor),
      .rem_out (rem_step),
      .q_bit   (q_bits[0])
   );
`endif

   assign q_acc_next = {q_acc[DIVIDEND_W-STEPS_PER_CYC-1:0], q_bits};
   assign in_ready   = (state == IDLE);
   assign out_valid  = (state == DONE);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: if (in_valid)        state_next = CALC;
         CALC: if (cnt == LAST_CNT) state_next = DONE;
         DONE: if (out_ready)       state_next = IDLE;
         default:                   state_next = IDLE;
      endcase
   end

   // Results are published only on the final CALC step so Q/R/dz hold steady otherwise.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt     <= '0;
         dvd     <= '0;
         divisor <= '0;
         rem     <= '0;
         q_acc   <= '0;
         Q       <= '0;
         R       <= '0;
         dz      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  dvd     <= P;
                  divisor <= B;
                  rem     <= '0;
                  cnt     <= '0;
                  q_acc   <= '0;
               end
            end
            CALC: begin
               rem   <= rem_step;
               dvd   <= dvd << STEPS_PER_CYC;
               q_acc <= q_acc_next;
               cnt   <= cnt + 1'b1;
               if (cnt == LAST_CNT) begin
                  Q  <= q_acc_next;
                  R  <= rem_step[DIVISOR_W-1:0];
                  dz <= (divisor == '0);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_div8by4_seq.sv
// Self-checking bench for div8by4_seq: directed table, handshake/reset corner
// sequences, randomized traffic against an arithmetic model, and a full operand sweep.
module tb_div8by4_seq;

`ifdef DIV_RADIX4_EN
   localparam int LAT = 4;
`else
   localparam int LAT = 8;
`endif

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] P;
   logic [3:0] B;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] Q;
   logic [3:0] R;
   logic       dz;

   int n_checks = 0;
   int n_errors = 0;
   int n_accepted = 0;
   int n_results = 0;

   div8by4_seq dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .P         (P),
      .B         (B),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .Q         (Q),
      .R         (R),
      .dz        (dz)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (rst_n && in_valid && in_ready)   n_accepted++;
      if (rst_n && out_valid && out_ready) n_results++;
   end

   typedef struct {
      logic [7:0] p;
      logic [3:0] b;
      logic [7:0] q;
      logic [3:0] r;
      logic       dz;
   } vec_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check_output(input string name, input int actual, input int expected);
      n_checks++;
      if (actual !== expected) begin
         n_errors++;
         $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
      end
   endtask

   // Reference: plain integer division, with divide-by-zero giving all-ones quotient.
   task automatic model(input logic [7:0] p, input logic [3:0] b,
                        output logic [7:0] q, output logic [3:0] r, output logic z);
      if (b == 4'd0) begin
         q = 8'hFF;
         r = p[3:0];
         z = 1'b1;
      end else begin
         q = 8'(int'(p) / int'(b));
         r = 4'(int'(p) % int'(b));
         z = 1'b0;
      end
   endtask

   // Offers one pair, waits for the result, optionally stalls the consumer, then takes it.
   task automatic apply_stimulus(input logic [7:0] p, input logic [3:0] b, input int stall,
                                 output logic [7:0] q, output logic [3:0] r, output logic z,
                                 output int lat, output bit busy_ok);
      int w;
      busy_ok   = 1'b1;
      w         = 0;
      out_ready = 1'b0;
      while (!in_ready && w < 40) begin
         tick();
         w++;
      end
      P        = p;
      B        = b;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      P        = 8'($urandom);
      B        = 4'($urandom);
      lat      = 0;
      while (!out_valid && lat < 40) begin
         if (in_ready) busy_ok = 1'b0;
         tick();
         lat++;
      end
      q = Q;
      r = R;
      z = dz;
      repeat (stall) begin
         if (in_ready) busy_ok = 1'b0;
         tick();
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   vec_t       vecs[10];
   logic [7:0] q_got, q_exp;
   logic [3:0] r_got, r_exp;
   logic       z_got, z_exp;
   int         lat;
   bit         busy_ok;
   int         acc_cyc[2];
   int         n_acc;
   int         acc_before, res_before;

   initial begin
      vecs[0] = '{p: 8'd200, b: 4'd7,  q: 8'd28,  r: 4'd4,  dz: 1'b0};
      vecs[1] = '{p: 8'd255, b: 4'd1,  q: 8'd255, r: 4'd0,  dz: 1'b0};
      vecs[2] = '{p: 8'd225, b: 4'd15, q: 8'd15,  r: 4'd0,  dz: 1'b0};
      vecs[3] = '{p: 8'd9,   b: 4'd0,  q: 8'hFF,  r: 4'd9,  dz: 1'b1};
      vecs[4] = '{p: 8'd0,   b: 4'd13, q: 8'd0,   r: 4'd0,  dz: 1'b0};
      vecs[5] = '{p: 8'd100, b: 4'd3,  q: 8'd33,  r: 4'd1,  dz: 1'b0};
      vecs[6] = '{p: 8'd254, b: 4'd15, q: 8'd16,  r: 4'd14, dz: 1'b0};
      vecs[7] = '{p: 8'd7,   b: 4'd8,  q: 8'd0,   r: 4'd7,  dz: 1'b0};
      vecs[8] = '{p: 8'd0,   b: 4'd0,  q: 8'hFF,  r: 4'd0,  dz: 1'b1};
      vecs[9] = '{p: 8'd255, b: 4'd0,  q: 8'hFF,  r: 4'd15, dz: 1'b1};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      P         = '0;
      B         = '0;
      repeat (3) tick();
      check_output("reset_in_ready",  in_ready,  1);
      check_output("reset_out_valid", out_valid, 0);
      check_output("reset_Q",  Q,  0);
      check_output("reset_R",  R,  0);
      check_output("reset_dz", dz, 0);
      rst_n = 1'b1;
      tick();

      $display("[TB] directed table");
      for (int i = 0; i < 10; i++) begin
         apply_stimulus(vecs[i].p, vecs[i].b, 0, q_got, r_got, z_got, lat, busy_ok);
         check_output($sformatf("vec%0d_Q", i),  q_got, vecs[i].q);
         check_output($sformatf("vec%0d_R", i),  r_got, vecs[i].r);
         check_output($sformatf("vec%0d_dz", i), z_got, vecs[i].dz);
         check_output($sformatf("vec%0d_latency", i), lat, LAT);
         check_output($sformatf("vec%0d_in_ready_low", i), busy_ok, 1);
         check_output($sformatf("vec%0d_back_to_idle", i), in_ready, 1);
      end

      $display("[TB] consumer stall with ignored in_valid pulses");
      P = 8'd0;
      B = 4'd13;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check_output("stall_latency", lat, LAT);
      for (int c = 0; c < 5; c++) begin
         P = 8'd77;
         B = 4'd2;
         in_valid = c[0];
         tick();
         check_output($sformatf("stall%0d_out_valid", c), out_valid, 1);
         check_output($sformatf("stall%0d_Q", c), Q, 0);
         check_output($sformatf("stall%0d_R", c), R, 0);
         check_output($sformatf("stall%0d_in_ready", c), in_ready, 0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
      check_output("stall_release_out_valid", out_valid, 0);
      check_output("stall_release_in_ready",  in_ready,  1);
      repeat (LAT + 2) tick();
      check_output("stall_no_ghost_result", out_valid, 0);

      $display("[TB] reset in the 4th CALC cycle");
      P = 8'd100;
      B = 4'd3;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_output("midrst_in_ready",  in_ready,  1);
      check_output("midrst_out_valid", out_valid, 0);
      check_output("midrst_Q", Q, 0);
      check_output("midrst_R", R, 0);
      repeat (LAT + 2) tick();
      check_output("midrst_no_result", out_valid, 0);
      apply_stimulus(8'd100, 4'd3, 0, q_got, r_got, z_got, lat, busy_ok);
      check_output("post_rst_Q", q_got, 33);
      check_output("post_rst_R", r_got, 1);

      $display("[TB] reset while holding a result");
      P = 8'd200;
      B = 4'd7;
      in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = 0;
      while (!out_valid && lat < 40) begin
         tick();
         lat++;
      end
      check_output("donerst_Q_before", Q, 28);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check_output("donerst_out_valid", out_valid, 0);
      check_output("donerst_Q", Q, 0);
      check_output("donerst_R", R, 0);

      $display("[TB] throughput with out_ready held high");
      P = 8'd50;
      B = 4'd5;
      in_valid  = 1'b1;
      out_ready = 1'b1;
      acc_cyc[0] = 0;
      acc_cyc[1] = 0;
      n_acc = 0;
      for (int c = 0; c < 4 * LAT; c++) begin
         if (in_ready && n_acc < 2) begin
            acc_cyc[n_acc] = c;
            n_acc++;
         end
         tick();
      end
      in_valid = 1'b0;
      check_output("throughput_interval", acc_cyc[1] - acc_cyc[0], LAT + 2);
      for (int c = 0; c < 40 && !(in_ready && !out_valid); c++) tick();
      out_ready = 1'b0;

      $display("[TB] randomized traffic");
      for (int i = 0; i < 300; i++) begin
         logic [7:0] rp;
         logic [3:0] rb;
         rp = 8'($urandom);
         rb = 4'($urandom);
         repeat ($urandom_range(0, 2)) tick();
         apply_stimulus(rp, rb, $urandom_range(0, 3), q_got, r_got, z_got, lat, busy_ok);
         model(rp, rb, q_exp, r_exp, z_exp);
         check_output($sformatf("rand%0d_Q(P=%0d,B=%0d)", i, rp, rb), q_got, q_exp);
         check_output($sformatf("rand%0d_R(P=%0d,B=%0d)", i, rp, rb), r_got, r_exp);
         check_output($sformatf("rand%0d_dz", i), z_got, z_exp);
         check_output($sformatf("rand%0d_latency", i), lat, LAT);
      end

      $display("[TB] exhaustive sweep");
      acc_before = n_accepted;
      res_before = n_results;
      for (int pi = 0; pi < 256; pi++) begin
         for (int bi = 0; bi < 16; bi++) begin
            apply_stimulus(8'(pi), 4'(bi), 0, q_got, r_got, z_got, lat, busy_ok);
            model(8'(pi), 4'(bi), q_exp, r_exp, z_exp);
            check_output($sformatf("sweep_Q(P=%0d,B=%0d)", pi, bi), q_got, q_exp);
            check_output($sformatf("sweep_R(P=%0d,B=%0d)", pi, bi), r_got, r_exp);
            check_output($sformatf("sweep_dz(P=%0d,B=%0d)", pi, bi), z_got, z_exp);
         end
      end
      check_output("sweep_accept_count", n_accepted - acc_before, 4096);
      check_output("sweep_result_count", n_results - res_before, 4096);

      $display("[TB] Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
